// File: rtl/sdram_owner_scheduler.sv
// sdram_owner_scheduler
// Decides when the Nios may take the SDRAM away from the camera, drives the
// arbiter request, and forces the SDRAM back to the camera when the Nios
// tenure runs too long or the camera FIFO is close to overflowing.
// All outputs are registered and are decoded from the next state, so they
// change in the same cycle as the state they belong to.

module sdram_owner_scheduler #(
    parameter int MAX_NIOS_CYCLES = 4096,
    parameter int FIFO_HIGH       = 768,
    parameter int SWITCH_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        NiosReq,
    input  logic        NiosDone,
    input  logic        CamFrameEnd,
    input  logic [9:0]  CamFifoLevel,
    input  logic        NiosHasControl,
    input  logic        CamHasControl,
    output logic        RequestNiosControl,
    output logic        NiosGrant,
    output logic        CamStall,
    output logic        Preempt,
    output logic        SwitchTimeout,
    output logic [15:0] GrantCount
);

    typedef enum logic [2:0] {
        ST_CAM        = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_TO_NIOS    = 3'd2,
        ST_NIOS       = 3'd3,
        ST_TO_CAM     = 3'd4
    } state_t;

    // Last hold/switch counter values before a forced exit.
    localparam logic [15:0] HOLD_LAST   = 16'(MAX_NIOS_CYCLES - 1);
    localparam logic [15:0] SWITCH_LAST = 16'(SWITCH_TIMEOUT - 1);
    // One extra bit so a threshold above the 10-bit range simply never fires.
    localparam logic [10:0] FIFO_LIMIT  = 11'(FIFO_HIGH);

    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] switch_q, switch_d;
    logic [15:0] count_q, count_d;
    logic        req_q, req_d;
    logic        grant_q, grant_d;
    logic        stall_q, stall_d;
    logic        preempt_q, preempt_d;
    logic        timeout_q, timeout_d;

    logic        fifo_high_s;
    logic        nios_exit_s;

    assign fifo_high_s = ({1'b0, CamFifoLevel} >= FIFO_LIMIT);
    assign nios_exit_s = NiosDone | ~NiosReq | (hold_q == HOLD_LAST) | fifo_high_s;

    // Next-state, counter and output decode for the ownership FSM.
    always_comb begin
        state_d   = state_q;
        hold_d    = 16'd0;
        switch_d  = 16'd0;
        count_d   = count_q;
        preempt_d = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            ST_CAM: begin
                if (NiosReq) begin
                    state_d = CamFrameEnd ? ST_TO_NIOS : ST_WAIT_FRAME;
                end else begin
                    state_d = ST_CAM;
                end
            end
            ST_WAIT_FRAME: begin
                // A frame end wins over a withdrawn request in the same cycle.
                if (CamFrameEnd) begin
                    state_d = ST_TO_NIOS;
                end else if (!NiosReq) begin
                    state_d = ST_CAM;
                end else begin
                    state_d = ST_WAIT_FRAME;
                end
            end
            ST_TO_NIOS: begin
                if (NiosHasControl) begin
                    state_d = ST_NIOS;
                end else if (switch_q == SWITCH_LAST) begin
                    state_d   = ST_TO_CAM;
                    timeout_d = 1'b1;
                end else begin
                    switch_d = switch_q + 16'd1;
                end
            end
            ST_NIOS: begin
                if (nios_exit_s) begin
                    state_d   = ST_TO_CAM;
                    // Only a forced exit (Nios still wants the bus) is a preemption.
                    preempt_d = ~NiosDone & NiosReq;
                    count_d   = (count_q == 16'hFFFF) ? count_q : (count_q + 16'd1);
                end else begin
                    hold_d = hold_q + 16'd1;
                end
            end
            ST_TO_CAM: begin
                if (CamHasControl) begin
                    state_d = ST_CAM;
                end else begin
                    state_d = ST_TO_CAM;
                end
            end
            default: begin
                state_d = ST_TO_CAM;
            end
        endcase

        req_d   = (state_d == ST_TO_NIOS) || (state_d == ST_NIOS);
        grant_d = (state_d == ST_NIOS);
        stall_d = (state_d == ST_TO_NIOS) || (state_d == ST_NIOS) || (state_d == ST_TO_CAM);
    end

    // State, counters and registered outputs; reset hands the SDRAM back to the camera.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= ST_TO_CAM;
            hold_q    <= 16'd0;
            switch_q  <= 16'd0;
            count_q   <= 16'd0;
            req_q     <= 1'b0;
            grant_q   <= 1'b0;
            stall_q   <= 1'b1;
            preempt_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            switch_q  <= switch_d;
            count_q   <= count_d;
            req_q     <= req_d;
            grant_q   <= grant_d;
            stall_q   <= stall_d;
            preempt_q <= preempt_d;
            timeout_q <= timeout_d;
        end
    end

    assign RequestNiosControl = req_q;
    assign NiosGrant          = grant_q;
    assign CamStall           = stall_q;
    assign Preempt            = preempt_q;
    assign SwitchTimeout      = timeout_q;
    assign GrantCount         = count_q;

endmodule

// File: tb/tb_sdram_owner_scheduler.sv
// Bench for sdram_owner_scheduler: two instances (default tenure limit and a
// tenure limit of 8) share one stimulus stream and are compared every cycle
// against a phase/dwell-time reference model.

module tb_sdram_owner_scheduler;

    logic        clk = 1'b0;
    logic        Reset;
    logic        NiosReq;
    logic        NiosDone;
    logic        CamFrameEnd;
    logic [9:0]  CamFifoLevel;
    logic        NiosHasControl;
    logic        CamHasControl;

    logic [1:0]  req_w;
    logic [1:0]  grant_w;
    logic [1:0]  stall_w;
    logic [1:0]  pre_w;
    logic [1:0]  sto_w;
    logic [15:0] cnt_w [2];

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 CAM, 1 WAIT_FRAME, 2 TO_NIOS, 3 NIOS, 4 TO_CAM.
    int ph    [2];
    int tk    [2];   // cycles already spent in the current phase
    int e_pre [2];
    int e_sto [2];
    int e_cnt [2];
    int maxc  [2] = '{4096, 8};
    localparam int SW_TO = 16;
    localparam int FIFO_H = 768;

    int gcnt [2];
    int pcnt [2];

    always #5 clk = ~clk;

    sdram_owner_scheduler u_dut (
        .clk(clk), .Reset(Reset), .NiosReq(NiosReq), .NiosDone(NiosDone),
        .CamFrameEnd(CamFrameEnd), .CamFifoLevel(CamFifoLevel),
        .NiosHasControl(NiosHasControl), .CamHasControl(CamHasControl),
        .RequestNiosControl(req_w[0]), .NiosGrant(grant_w[0]), .CamStall(stall_w[0]),
        .Preempt(pre_w[0]), .SwitchTimeout(sto_w[0]), .GrantCount(cnt_w[0])
    );

    sdram_owner_scheduler #(.MAX_NIOS_CYCLES(8)) u_dut8 (
        .clk(clk), .Reset(Reset), .NiosReq(NiosReq), .NiosDone(NiosDone),
        .CamFrameEnd(CamFrameEnd), .CamFifoLevel(CamFifoLevel),
        .NiosHasControl(NiosHasControl), .CamHasControl(CamHasControl),
        .RequestNiosControl(req_w[1]), .NiosGrant(grant_w[1]), .CamStall(stall_w[1]),
        .Preempt(pre_w[1]), .SwitchTimeout(sto_w[1]), .GrantCount(cnt_w[1])
    );

    task automatic check(input string tag, input int m, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed %0h expected %0h", tag, m, obs, exp);
        end
    endtask

    task automatic model_update();
        for (int m = 0; m < 2; m++) begin
            int nxt;
            if (Reset) begin
                ph[m] = 4; tk[m] = 0; e_pre[m] = 0; e_sto[m] = 0; e_cnt[m] = 0;
            end else begin
                nxt = ph[m];
                e_pre[m] = 0;
                e_sto[m] = 0;
                case (ph[m])
                    0: if (NiosReq) nxt = CamFrameEnd ? 2 : 1;
                    1: if (CamFrameEnd) nxt = 2; else if (!NiosReq) nxt = 0;
                    2: if (NiosHasControl) nxt = 3;
                       else if (tk[m] == SW_TO - 1) begin nxt = 4; e_sto[m] = 1; end
                    3: if (NiosDone || !NiosReq || tk[m] == maxc[m] - 1 || CamFifoLevel >= FIFO_H) begin
                           nxt = 4;
                           e_pre[m] = (!NiosDone && NiosReq) ? 1 : 0;
                           if (e_cnt[m] < 65535) e_cnt[m]++;
                       end
                    4: if (CamHasControl) nxt = 0;
                    default: nxt = 4;
                endcase
                tk[m] = (nxt != ph[m]) ? 0 : tk[m] + 1;
                ph[m] = nxt;
            end
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            check("req",     m, {15'd0, req_w[m]},   (ph[m] == 2 || ph[m] == 3) ? 16'd1 : 16'd0);
            check("grant",   m, {15'd0, grant_w[m]}, (ph[m] == 3) ? 16'd1 : 16'd0);
            check("stall",   m, {15'd0, stall_w[m]}, (ph[m] >= 2) ? 16'd1 : 16'd0);
            check("preempt", m, {15'd0, pre_w[m]},   16'(e_pre[m]));
            check("swtmo",   m, {15'd0, sto_w[m]},   16'(e_sto[m]));
            check("gcount",  m, cnt_w[m],            16'(e_cnt[m]));
            if (grant_w[m]) gcnt[m]++;
            if (pre_w[m])   pcnt[m]++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        Reset = 1'b1; NiosReq = 1'b0; NiosDone = 1'b0; CamFrameEnd = 1'b0;
        CamFifoLevel = 10'd0; NiosHasControl = 1'b0; CamHasControl = 1'b0;
        for (int m = 0; m < 2; m++) begin
            ph[m] = 4; tk[m] = 0; e_pre[m] = 0; e_sto[m] = 0; e_cnt[m] = 0;
            gcnt[m] = 0; pcnt[m] = 0;
        end
        #2;
        ticks(2);
        check("rst_stall", 0, {15'd0, stall_w[0]}, 16'd1);
        check("rst_req",   0, {15'd0, req_w[0]},   16'd0);

        // Leave reset; camera gets the SDRAM back once the arbiter reports it.
        Reset = 1'b0;
        ticks(3);
        CamHasControl = 1'b1; tick(); CamHasControl = 1'b0;
        check("cam_stall0", 0, {15'd0, stall_w[0]}, 16'd0);
        check("cam_count0", 0, cnt_w[0], 16'd0);

        // Voluntary tenure (instance 0) vs tenure-limit preemption (instance 1).
        NiosReq = 1'b1; ticks(10);
        check("wait_noreq", 0, {15'd0, req_w[0]}, 16'd0);
        CamFrameEnd = 1'b1; tick(); CamFrameEnd = 1'b0;
        check("req_rise", 0, {15'd0, req_w[0]}, 16'd1);
        ticks(3);
        for (int m = 0; m < 2; m++) begin gcnt[m] = 0; pcnt[m] = 0; end
        NiosHasControl = 1'b1; tick();
        ticks(15);
        NiosDone = 1'b1; tick(); NiosDone = 1'b0;
        tick();
        check("tenure_len",   0, 16'(gcnt[0]), 16'd16);
        check("tenure_len8",  1, 16'(gcnt[1]), 16'd8);
        check("no_preempt",   0, 16'(pcnt[0]), 16'd0);
        check("one_preempt8", 1, 16'(pcnt[1]), 16'd1);
        check("count1",       0, cnt_w[0], 16'd1);
        NiosReq = 1'b0; NiosHasControl = 1'b0; CamHasControl = 1'b1; tick(); CamHasControl = 1'b0;

        // FIFO threshold: 767 keeps the Nios, 768 forces it off.
        NiosReq = 1'b1; CamFrameEnd = 1'b1; tick(); CamFrameEnd = 1'b0;
        NiosHasControl = 1'b1; tick();
        CamFifoLevel = 10'd767; ticks(3);
        check("fifo767_grant", 0, {15'd0, grant_w[0]}, 16'd1);
        CamFifoLevel = 10'd768; tick(); CamFifoLevel = 10'd0;
        check("fifo768_grant", 0, {15'd0, grant_w[0]}, 16'd0);
        check("fifo768_pre",   0, {15'd0, pre_w[0]},   16'd1);
        NiosReq = 1'b0; NiosHasControl = 1'b0; CamHasControl = 1'b1; tick(); CamHasControl = 1'b0;

        // Arbiter never hands over: timeout after 16 TO_NIOS cycles.
        NiosReq = 1'b1; CamFrameEnd = 1'b1; tick(); CamFrameEnd = 1'b0;
        ticks(15);
        check("sto_early", 0, {15'd0, sto_w[0]}, 16'd0);
        tick();
        check("sto_pulse", 0, {15'd0, sto_w[0]}, 16'd1);
        check("sto_count", 0, cnt_w[0], 16'd2);
        NiosReq = 1'b0; CamHasControl = 1'b1; tick(); CamHasControl = 1'b0;

        // Request withdrawn before frame end, then a stray NiosDone in CAM.
        NiosReq = 1'b1; tick(); NiosReq = 1'b0; tick();
        NiosDone = 1'b1; tick(); NiosDone = 1'b0;
        check("stray_done_stall", 0, {15'd0, stall_w[0]}, 16'd0);
        check("stray_done_grant", 0, {15'd0, grant_w[0]}, 16'd0);

        // Reset in the middle of a tenure aborts without preemption.
        NiosReq = 1'b1; CamFrameEnd = 1'b1; tick(); CamFrameEnd = 1'b0;
        NiosHasControl = 1'b1; ticks(3);
        Reset = 1'b1; tick(); Reset = 1'b0;
        check("rst_mid_pre",   0, {15'd0, pre_w[0]}, 16'd0);
        check("rst_mid_count", 0, cnt_w[0], 16'd0);
        NiosReq = 1'b0; NiosHasControl = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7, 0) == 0) NiosReq = ~NiosReq;
            CamFrameEnd    = ($urandom_range(5, 0) == 0);
            NiosDone       = ($urandom_range(19, 0) == 0);
            NiosHasControl = ($urandom_range(2, 0) == 0);
            CamHasControl  = ($urandom_range(2, 0) == 0);
            CamFifoLevel   = ($urandom_range(29, 0) == 0) ? 10'($urandom_range(1023, 700))
                                                          : 10'($urandom_range(700, 0));
            Reset          = ($urandom_range(499, 0) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
